// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared types and address width for the redirect path.
package mips_core_pkg;

  // Mirrors `ADDR_WIDTH in mips_core.svh; keep the two in step.
  localparam int CORE_ADDR_WIDTH = 26;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_DEC  = 2'd1,
    SRC_EX   = 2'd2
  } redirect_src_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } redirect_state_t;

endpackage

// File: rtl/pc_redirect_unit_stat_counter.sv
// rtl/pc_redirect_unit_stat_counter.sv - 32-bit saturating event counter.
module redirect_stat_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 32'd0;
    end else if (inc && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - arbitrates decode/execute redirects into fetch load_pc; REDIRECT_STATS_EN adds per-source counters.
module pc_redirect_unit
  import mips_core_pkg::*;
#(
  parameter int ADDR_WIDTH = CORE_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_stall,
  input  logic                  i_dec_valid,
  input  logic [ADDR_WIDTH-1:0] i_dec_target,
  input  logic                  i_ex_valid,
  input  logic [ADDR_WIDTH-1:0] i_ex_target,
  output logic                  o_load_we,
  output logic [ADDR_WIDTH-1:0] o_load_new_pc,
  output logic                  o_flush_if,
  output logic                  o_flush_id,
`ifdef REDIRECT_STATS_EN
  output logic [31:0]           o_dec_redirects,
  output logic [31:0]           o_ex_redirects,
`endif
  output logic                  o_pending
);

  redirect_state_t       state, next_state;
  redirect_src_t         held_src, next_src;
  logic [ADDR_WIDTH-1:0] held_target, next_target;

  redirect_src_t         win_src;
  logic [ADDR_WIDTH-1:0] win_target;
  logic                  win_valid;
  logic                  accept;

  // Execute always wins: it resolves an older instruction, so any
  // concurrent or held decode redirect is on the wrong path.
  always_comb begin
    win_src    = SRC_NONE;
    win_target = '0;
    if (i_ex_valid) begin
      win_src    = SRC_EX;
      win_target = i_ex_target;
    end else if (state == HOLD) begin
      win_src    = held_src;
      win_target = held_target;
    end else if (i_dec_valid) begin
      win_src    = SRC_DEC;
      win_target = i_dec_target;
    end
  end

  assign win_valid = (win_src != SRC_NONE);
  assign accept    = win_valid && !i_stall;

  always_comb begin
    o_load_we     = win_valid;
    o_load_new_pc = '0;
    if (win_valid) begin
      o_load_new_pc = {win_target[ADDR_WIDTH-1:2], 2'b00};
    end
    o_flush_if = accept;
    o_flush_id = accept && (win_src == SRC_EX);
    o_pending  = (state == HOLD);
  end

  // Any unaccepted winner is (re)captured, which also covers an execute
  // request replacing a held entry while fetch stays stalled.
  always_comb begin
    next_state  = state;
    next_src    = held_src;
    next_target = held_target;
    if (win_valid && i_stall) begin
      next_state  = HOLD;
      next_src    = win_src;
      next_target = win_target;
    end else if (state == HOLD) begin
      next_state = IDLE;
      next_src   = SRC_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      held_src    <= SRC_NONE;
      held_target <= '0;
    end else begin
      state       <= next_state;
      held_src    <= next_src;
      held_target <= next_target;
    end
  end

`ifdef REDIRECT_STATS_EN
  redirect_stat_counter u_dec_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept && (win_src == SRC_DEC)),
    .count (o_dec_redirects)
  );

  redirect_stat_counter u_ex_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept && (win_src == SRC_EX)),
    .count (o_ex_redirects)
  );
`endif

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Initiator side of the load-pc interface consumed by the fetch stage.
- Collects control-flow redirects from decode (jumps/predicted-taken branches) and execute (branch mispredict resolution) and arbitrates between them.
- Drives the fetch stage's load_pc we/new_pc and generates pipeline flushes.
- A redirect raised while fetch is stalled would be lost, because fetch ignores load_pc when stalled. This block therefore holds the redirect until fetch accepts it.

Parameters:
ADDR_WIDTH, 26, byte-address width, must match `ADDR_WIDTH in mips_core.svh

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
i_stall  input  1  same stall fetch sees; redirect accepted only in cycle with i_stall=0
i_dec_valid  input  1  decode-stage redirect request
i_dec_target  input  ADDR_WIDTH  decode redirect target
i_ex_valid  input  1  execute-stage redirect request (mispredict)
i_ex_target  input  ADDR_WIDTH  execute redirect target
o_load_we  output  1  load_pc.we to fetch
o_load_new_pc  output  ADDR_WIDTH  load_pc.new_pc to fetch
o_flush_if  output  1  kill instruction in IF/ID register
o_flush_id  output  1  kill instruction in ID/EX register
o_pending  output  1  redirect held, waiting for stall release

Behaviour:
- States: IDLE, HOLD. Registers: state, held_target, held_src (SRC_NONE/SRC_DEC/SRC_EX).
- Reset (rst=1 at posedge): state=IDLE, held_target=0, held_src=SRC_NONE. All outputs 0 while in IDLE with no requests.
- Priority: execute over decode, because execute holds the older instruction and a simultaneous decode request is wrong-path and is dropped.
- Winner selection each cycle, in order:
  - i_ex_valid gives the ex request.
  - Else held entry if state=HOLD.
  - Else i_dec_valid gives the dec request.
  - In HOLD with held_src=SRC_EX, a new i_dec_valid is ignored.
  - A new i_ex_valid replaces any held entry.
- Outputs are combinational from the winner (zero-latency path, matching fetch's combinational use of we):
  - o_load_we=1 whenever a winner exists.
  - o_load_new_pc = winner target with bits [1:0] forced to 0.
  - No winner: o_load_we=0, o_load_new_pc=0.
- Acceptance = o_load_we & !i_stall. In the acceptance cycle:
  - o_flush_if=1.
  - o_flush_id=1 only if winner source is SRC_EX.
  - Flushes are 0 in all non-acceptance cycles.
- Transitions:
  - IDLE, winner, !i_stall: accept, stay IDLE.
  - IDLE, winner, i_stall: capture target/src, go HOLD.
  - HOLD, !i_stall: accept winner, go IDLE, held_src=SRC_NONE.
  - HOLD, i_stall: stay HOLD; recapture if an ex request replaced the entry.
- o_pending = (state==HOLD), registered.
- Reset mid-HOLD discards the held redirect. Next cycle is IDLE with no load.
- Back-to-back accepted redirects on consecutive cycles are legal. Each cycle is independent.

Optional Feature:
- Macro: REDIRECT_STATS_EN.
- Defined:
  - Adds outputs o_dec_redirects[31:0] and o_ex_redirects[31:0].
  - Each counts accepted redirects per source.
  - Counters saturate at 32'hFFFF_FFFF, reset to 0 on rst, and increment exactly once per acceptance, never during HOLD cycles.
- Undefined: ports and counters absent. Core behaviour is identical.

Decomposition:
- mips_core_pkg holds:
  - typedef enum logic [1:0] redirect_src_t {SRC_NONE, SRC_DEC, SRC_EX}.
  - typedef enum logic redirect_state_t {IDLE, HOLD}.
  - ADDR_WIDTH comes from mips_core.svh.
- One sub-module: redirect_stat_counter, a 32-bit saturating counter with inc input, instantiated twice under REDIRECT_STATS_EN.

Test Plan:
1. Reset held 2 cycles, then i_dec_valid=1, target=26'h000_0040, i_stall=0 -> same cycle o_load_we=1, new_pc=26'h40, flush_if=1, flush_id=0, o_pending stays 0.
2. i_dec_valid=1, target=26'h80 with i_stall=1 for 3 cycles, then i_stall=0 (dec_valid pulsed 1 cycle) -> o_pending=1 for 3 cycles, o_load_we=1/new_pc=26'h80 throughout, flush_if only in release cycle, then IDLE.
3. Same cycle i_dec_valid=1 (26'h100), i_ex_valid=1 (26'h200), no stall -> new_pc=26'h200, flush_if=1, flush_id=1.
4. HOLD with dec 26'h100 under stall, then i_ex_valid=1 target 26'h300 while still stalled, then release -> accepted new_pc=26'h300, flush_id=1; a later dec request during HOLD(SRC_EX) is ignored.
5. Unaligned i_ex_target=26'h107 -> new_pc=26'h104; rst=1 asserted during HOLD -> next cycle o_pending=0, o_load_we=0.
6. With REDIRECT_STATS_EN: 5 dec and 3 ex accepted redirects, one of them stalled 4 cycles -> o_dec_redirects=5, o_ex_redirects=3; preload near max -> saturates at 32'hFFFF_FFFF.
